learn_seq_ctrl: RTL and testbench
=================================

// Module: learn_seq_ctrl
// PURPOSE
//  Sequencer for learn mode: steps through a song ROM and presents each expected note.
//  Waits until the player presses and holds a note key, then judges it correct or wrong.
//  Input is note_in, the 0..7 note code from the one-hot key decoder (0 = no/invalid key).
//  Drives the ROM address and hint LEDs, and reports hit/miss pulses and an error count.
// PARAMETERS
//  ADDR_W      5     song ROM address width; max song length 2**ADDR_W notes
//  DEB_CYCLES  20    consecutive identical note_in samples needed to accept a press/release (>=2)
//  TIMEOUT     1000  cycles allowed in WAIT_KEY before the note is scored a miss and skipped
//  ERR_W       8     error counter width
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       asynchronous active-low reset
//  start          in   1       1-cycle pulse; begins a song from address 0 (ignored when busy=1)
//  abort          in   1       level; forces return to IDLE
//  note_in        in   4       decoded key note, 0..7; 0 = none
//  rom_addr       out  ADDR_W  song ROM address
//  rom_note       in   4       ROM data, valid 1 cycle after rom_addr changes; 0 = end-of-song
//  expected_note  out  4       note the player must press; 0 when not in a song
//  busy           out  1       high from the cycle after start until DONE or abort
//  hit            out  1       1-cycle pulse: correct key accepted
//  miss           out  1       1-cycle pulse: wrong key accepted, or timeout
//  done           out  1       1-cycle pulse: song completed
//  err_cnt        out  ERR_W   misses this song; saturates at all-ones
// BEHAVIOUR
//  Reset: state IDLE; rom_addr=0, expected_note=0, busy/hit/miss/done=0, err_cnt=0,
//   debounce and timeout counters = 0.
//  Debounce: deb_cnt clears whenever note_in != previous-cycle sample, else increments
//   (saturating). A value is "stable" when deb_cnt >= DEB_CYCLES-1.
//  IDLE: on start -> FETCH, rom_addr=0, err_cnt=0, busy=1.
//  FETCH (2 cycles: address, then data):
//   - rom_note==0 -> DONE.
//   - rom_note 1..7 -> latch expected_note -> WAIT_REL.
//   - rom_note 8..15 -> treated as end-of-song -> DONE.
//  WAIT_REL: waits for note_in==0 stable, so a held key never counts for the next note.
//   Then clears the timeout counter -> WAIT_KEY.
//  WAIT_KEY: timeout counter +1 per cycle.
//   - Stable nonzero note equal to expected_note: hit=1, rom_addr+1 -> ADVANCE.
//   - Stable nonzero note not equal: miss=1, err_cnt+1, same note kept -> WAIT_REL.
//   - Counter reaches TIMEOUT-1: miss=1, err_cnt+1, rom_addr+1 -> ADVANCE.
//   - Stable key and timeout in the same cycle: the key judgement wins; no extra miss.
//  ADVANCE: if rom_addr wrapped to 0 (last address already played) -> DONE, else -> FETCH.
//  DONE: done=1 for one cycle, busy=0, expected_note=0 -> IDLE. err_cnt holds until next start.
//  abort in any non-IDLE state: next cycle IDLE, busy=0, expected_note=0, no done pulse.
//   err_cnt holds. abort beats start when both are high.
//  start while busy is ignored. hit, miss and done are mutually exclusive and never stretched.
//  Latency: accept-cycle pulse is registered, so it appears 1 cycle after the stable condition.
// TESTING (DEB_CYCLES=4, TIMEOUT=50, ROM = 3,5,1,0)
//  T1: start; press 3, release, 5, release, 1, release, each held 6 cycles
//      -> 3 hit pulses, done once, err_cnt=0, busy low after done.
//  T2: on the first note press 4, release, then 3
//      -> miss then hit, expected_note stays 3 until the hit, err_cnt=1.
//  T3: no key for 60 cycles at note 1
//      -> miss at cycle 50 of WAIT_KEY, expected_note becomes 5, err_cnt=1.
//  T4: key 3 toggles 3/0 every 2 cycles (bounce), then held 4 cycles
//      -> exactly one hit, no miss; holding 3 into note 2 gives no judgement until released.
//  T5: abort during WAIT_KEY of note 2 -> IDLE next cycle, no done; start -> rom_addr=0, err_cnt=0.
//  T6: rst_n low mid-song -> all outputs reach reset values immediately, with no clock edge.

Source files
------------

// File: rtl/learn_seq_ctrl.sv
// Learn-mode sequencer: walks the song ROM, debounces the player's key and
// scores each note as hit or miss, counting misses per song.
module learn_seq_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int DEB_CYCLES = 20,
    parameter int TIMEOUT    = 1000,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        note_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_note,
    output logic [3:0]        expected_note,
    output logic              busy,
    output logic              hit,
    output logic              miss,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_A, S_FETCH_D, S_WAIT_REL, S_WAIT_KEY, S_ADVANCE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        exp_q, exp_d;
    logic [3:0]        prev_q;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [ERR_W-1:0]  err_q, err_d, err_inc;
    logic              busy_q, busy_d;
    logic              hit_q, hit_d, miss_q, miss_d, done_q, done_d;
    logic              stable;

    // deb_q counts repeats of prev_q; it parks at the threshold, so "stable"
    // means prev_q has been sampled DEB_CYCLES times in a row.
    assign stable  = (deb_q == DEB_W'(DEB_CYCLES - 1));
    assign deb_d   = (note_in != prev_q) ? '0 : (stable ? deb_q : deb_q + 1'b1);
    assign err_inc = (err_q == '1) ? err_q : err_q + 1'b1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        exp_d   = exp_q;
        busy_d  = busy_q;
        err_d   = err_q;
        to_d    = to_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_FETCH_A;
                    addr_d  = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH_A: state_d = S_FETCH_D;
            S_FETCH_D: begin
                // codes 8..15 are not playable notes, so they end the song
                if (rom_note != 4'd0 && !rom_note[3]) begin
                    exp_d   = rom_note;
                    state_d = S_WAIT_REL;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WAIT_REL: begin
                if (stable && prev_q == 4'd0) begin
                    to_d    = '0;
                    state_d = S_WAIT_KEY;
                end
            end
            S_WAIT_KEY: begin
                to_d = to_q + 1'b1;
                if (stable && prev_q != 4'd0) begin
                    if (prev_q == exp_q) begin
                        hit_d   = 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = S_ADVANCE;
                    end else begin
                        miss_d  = 1'b1;
                        err_d   = err_inc;
                        state_d = S_WAIT_REL;
                    end
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    miss_d  = 1'b1;
                    err_d   = err_inc;
                    addr_d  = addr_q + 1'b1;
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: state_d = (addr_q == '0) ? S_DONE : S_FETCH_A;
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                exp_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            exp_d   = 4'd0;
            addr_d  = addr_q;
            err_d   = err_q;
            hit_d   = 1'b0;
            miss_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            exp_q   <= '0;
            prev_q  <= '0;
            deb_q   <= '0;
            to_q    <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            exp_q   <= exp_d;
            prev_q  <= note_in;
            deb_q   <= deb_d;
            to_q    <= to_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr      = addr_q;
    assign expected_note = exp_q;
    assign busy          = busy_q;
    assign hit           = hit_q;
    assign miss          = miss_q;
    assign done          = done_q;
    assign err_cnt       = err_q;

endmodule

// File: tb/tb_learn_seq_ctrl.sv
// Directed bench for learn_seq_ctrl with DEB_CYCLES=4, TIMEOUT=50, song 3,5,1,0.
module tb_learn_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] note_in = 4'd0;
    logic [4:0] rom_addr;
    logic [3:0] rom_note = 4'd0;
    logic [3:0] expected_note;
    logic       busy, hit, miss, done;
    logic [7:0] err_cnt;

    logic [3:0] rom [32];
    int checks = 0;
    int errors = 0;
    int hit_n = 0, miss_n = 0, done_n = 0;
    int h0, m0, d0;

    learn_seq_ctrl #(.ADDR_W(5), .DEB_CYCLES(4), .TIMEOUT(50), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .note_in(note_in),
        .rom_addr(rom_addr), .rom_note(rom_note), .expected_note(expected_note),
        .busy(busy), .hit(hit), .miss(miss), .done(done), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // synchronous song ROM: data follows the address by one cycle
    always @(posedge clk) rom_note <= rom[rom_addr];

    always @(posedge clk) begin
        if (hit)  hit_n  <= hit_n + 1;
        if (miss) miss_n <= miss_n + 1;
        if (done) done_n <= done_n + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] n, input int cycles);
        note_in = n;
        repeat (cycles) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic snap();
        h0 = hit_n;
        m0 = miss_n;
        d0 = done_n;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 4'd0;
        rom[0] = 4'd3;
        rom[1] = 4'd5;
        rom[2] = 4'd1;
        rom[3] = 4'd0;

        // reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_exp", expected_note, 0);
        check("rst_pulses", {hit, miss, done}, 0);
        check("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // T1: clean play-through
        snap();
        do_start();
        check("t1_busy", busy, 1);
        check("t1_addr", rom_addr, 0);
        repeat (3) tick();
        check("t1_exp3", expected_note, 3);
        note_in = 4'd3;
        repeat (4) tick();
        check("t1_hit_early", hit, 0);
        tick();
        check("t1_hit_lat", hit, 1);
        check("t1_addr1", rom_addr, 1);
        tick();
        check("t1_hit_1cyc", hit, 0);
        hold(4'd0, 6);
        hold(4'd5, 6);
        hold(4'd0, 6);
        hold(4'd1, 6);
        hold(4'd0, 6);
        check("t1_hits", hit_n - h0, 3);
        check("t1_done", done_n - d0, 1);
        check("t1_miss", miss_n - m0, 0);
        check("t1_err", err_cnt, 0);
        check("t1_busy_end", busy, 0);
        check("t1_exp_end", expected_note, 0);

        // T2: wrong key then right key
        snap();
        do_start();
        repeat (3) tick();
        hold(4'd4, 6);
        check("t2_miss", miss_n - m0, 1);
        check("t2_err", err_cnt, 1);
        check("t2_exp_kept", expected_note, 3);
        hold(4'd0, 6);
        hold(4'd3, 6);
        check("t2_hit", hit_n - h0, 1);
        hold(4'd0, 6);
        check("t2_exp5", expected_note, 5);

        // T5: abort in WAIT_KEY of note 2, abort beats start, then restart
        abort = 1'b1;
        tick();
        check("t5_busy", busy, 0);
        check("t5_exp", expected_note, 0);
        check("t5_err_hold", err_cnt, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5_abort_wins", busy, 0);
        repeat (3) tick();
        check("t5_no_done", done_n - d0, 0);
        do_start();
        check("t5_restart_addr", rom_addr, 0);
        check("t5_restart_err", err_cnt, 0);
        check("t5_restart_busy", busy, 1);

        // T3: timeout on note 1, with a stray start that must be ignored
        snap();
        repeat (20) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (31) tick();
        check("t3_no_miss_yet", miss, 0);
        tick();
        check("t3_miss", miss, 1);
        check("t3_addr", rom_addr, 1);
        check("t3_err", err_cnt, 1);
        repeat (3) tick();
        check("t3_exp5", expected_note, 5);

        // T4: bounce gives nothing, steady hold gives one hit, held key into next note is ignored
        snap();
        repeat (3) begin
            hold(4'd5, 2);
            hold(4'd0, 2);
        end
        check("t4_bounce_hit", hit_n - h0, 0);
        check("t4_bounce_miss", miss_n - m0, 0);
        hold(4'd5, 6);
        check("t4_one_hit", hit_n - h0, 1);
        snap();
        hold(4'd5, 10);
        check("t4_held_hit", hit_n - h0, 0);
        check("t4_held_miss", miss_n - m0, 0);
        check("t4_exp1", expected_note, 1);
        hold(4'd0, 6);
        hold(4'd1, 6);
        hold(4'd0, 6);
        check("t4_done", done_n - d0, 1);
        check("t4_err", err_cnt, 1);
        check("t4_busy_end", busy, 0);

        // codes 8..15 end the song
        rom[1] = 4'd9;
        snap();
        do_start();
        repeat (3) tick();
        hold(4'd3, 6);
        hold(4'd0, 6);
        check("eos_hit", hit_n - h0, 1);
        check("eos_done", done_n - d0, 1);
        check("eos_busy", busy, 0);

        // T6: asynchronous reset mid-song
        do_start();
        repeat (3) tick();
        hold(4'd4, 6);
        check("t6_pre_err", err_cnt, 1);
        check("t6_pre_exp", expected_note, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_exp", expected_note, 0);
        check("t6_err", err_cnt, 0);
        check("t6_addr", rom_addr, 0);
        check("t6_pulses", {hit, miss, done}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
